alu_pkt_rx: RTL and testbench

ALU_PKT_RX -- requirements
Module: alu_pkt_rx

---
 rtl/alu_pkt_rx.sv | 153 +++++++++++++++
 tb/tb_alu_pkt_rx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pkt_rx.sv
// Serial ALU-packet receiver. Data frames build the B and A operands. A command
// frame closes the packet and carries op and a CRC-4. Results are held on a valid/ready output.
module alu_pkt_rx #(
   parameter int OPND_BYTES  = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    sin,
   output logic [8*OPND_BYTES-1:0] A,
   output logic [8*OPND_BYTES-1:0] B,
   output logic [2:0]              op,
   output logic [3:0]              err,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    drop
);
   localparam int W  = 8*OPND_BYTES;
   localparam int NB = 2*OPND_BYTES;
   localparam int CW = $clog2(NB+2);
   localparam int TW = $clog2(TIMEOUT_CYC+1);

   typedef enum logic [1:0] {IDLE, SHIFT, RESYNC} st_t;

   st_t           st, st_nxt;
   logic [3:0]    bit_cnt;
   logic [8:0]    fr;          // {ctl, d7..d0}
   logic [CW-1:0] byte_cnt;
   logic [TW-1:0] idle_cnt;
   logic [3:0]    crc;
   logic [2*W-1:0] data_sr;    // {B, A} once 2*OPND_BYTES bytes are in
   logic          stop_ok, stop_bad, tmo;
   logic          data_done, cmd_done, res_new, res_zero, load;
   logic [3:0]    crc_d, crc_c, res_err;
   logic [3:0]    cmd_bits;

   function automatic logic [3:0] crc_step(input logic [3:0] c, input logic b);
      logic fb;
      fb = c[3] ^ b;
      crc_step = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
   endfunction

   // bit FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st <= IDLE;
      else        st <= st_nxt;
   end

   // bit FSM: next state
   always_comb begin
      st_nxt = st;
      case (st)
         IDLE:    if (!sin) st_nxt = SHIFT;
         SHIFT:   if (bit_cnt == 4'd9) st_nxt = sin ? IDLE : RESYNC;
         RESYNC:  if (sin) st_nxt = IDLE;
         default: st_nxt = IDLE;
      endcase
   end

   // bit FSM: outputs
   always_comb begin
      stop_ok  = 1'b0;
      stop_bad = 1'b0;
      tmo      = 1'b0;
      case (st)
         SHIFT: begin
            stop_ok  = (bit_cnt == 4'd9) &&  sin;
            stop_bad = (bit_cnt == 4'd9) && !sin;
         end
         IDLE:    tmo = sin && (byte_cnt != '0) && (idle_cnt == TW'(TIMEOUT_CYC-1));
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt <= '0;
         fr      <= '0;
      end else if (st == SHIFT) begin
         bit_cnt <= (bit_cnt == 4'd9) ? 4'd0 : bit_cnt + 4'd1;
         if (bit_cnt != 4'd9) fr <= {fr[7:0], sin};
      end else begin
         bit_cnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                         idle_cnt <= '0;
      else if (st == IDLE && sin && byte_cnt != '0 && !tmo) idle_cnt <= idle_cnt + TW'(1);
      else                                                idle_cnt <= '0;
   end

   assign data_done = stop_ok && !fr[8];
   assign cmd_done  = stop_ok &&  fr[8];
   assign cmd_bits  = {1'b1, fr[6:4]};

   always_comb begin
      crc_d = crc;
      for (int i = 7; i >= 0; i--) crc_d = crc_step(crc_d, fr[i]);
      crc_c = crc;
      for (int i = 3; i >= 0; i--) crc_c = crc_step(crc_c, cmd_bits[i]);
   end

   // error priority: frame > count > CRC > op (illegal ops have op[1]=1)
   always_comb begin
      res_new  = stop_bad || cmd_done;
      res_zero = stop_bad || (byte_cnt != CW'(NB));
      if (stop_bad)                    res_err = 4'b1000;
      else if (byte_cnt != CW'(NB))    res_err = 4'b0100;
      else if (fr[3:0] != crc_c)       res_err = 4'b0010;
      else if (fr[5])                  res_err = 4'b0001;
      else                             res_err = 4'b0000;
      load = res_new && (!out_valid || out_ready);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt <= '0;
         crc      <= '0;
         data_sr  <= '0;
      end else if (res_new || tmo) begin
         byte_cnt <= '0;
         crc      <= '0;
         data_sr  <= '0;
      end else if (data_done) begin
         data_sr <= {data_sr[2*W-9:0], fr[7:0]};
         crc     <= crc_d;
         if (byte_cnt != CW'(NB+1)) byte_cnt <= byte_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         drop      <= 1'b0;
         A         <= '0;
         B         <= '0;
         op        <= '0;
         err       <= '0;
      end else begin
         drop <= (res_new && out_valid && !out_ready) || tmo;
         if (load) begin
            out_valid <= 1'b1;
            A         <= res_zero ? '0 : data_sr[W-1:0];
            B         <= res_zero ? '0 : data_sr[2*W-1:W];
            op        <= res_zero ? 3'b000 : fr[6:4];
            err       <= res_err;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_alu_pkt_rx.sv
// Random and directed packets for alu_pkt_rx, checked against a polynomial-division reference model.
module tb_alu_pkt_rx;
   localparam int OB  = 4;
   localparam int W   = 8*OB;
   localparam int TMO = 16;

   logic         clk = 1'b0;
   logic         rst_n, sin, out_ready;
   logic [W-1:0] A, B;
   logic [2:0]   op;
   logic [3:0]   err;
   logic         out_valid, drop;
   int           vec = 0, miss = 0;
   int           drop_cnt = 0, hs_cnt = 0;

   alu_pkt_rx #(.OPND_BYTES(OB), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .sin(sin), .A(A), .B(B), .op(op), .err(err),
      .out_valid(out_valid), .out_ready(out_ready), .drop(drop));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (drop) drop_cnt++;
      if (out_valid && out_ready) hs_cnt++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vec++;
      if (got !== exp) begin
         miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic idle(input int n);
      sin = 1'b1;
      tick(n);
   endtask

   task automatic send_frame(input logic ctl, input logic [7:0] d, input logic stop);
      logic [10:0] f;
      f = {1'b0, ctl, d, stop};
      for (int i = 10; i >= 0; i--) begin
         sin = f[i];
         tick(1);
      end
   endtask

   task automatic send_pkt(input logic [7:0] d[$], input logic [7:0] cmd, input int gmax);
      foreach (d[i]) begin
         send_frame(1'b0, d[i], 1'b1);
         idle($urandom_range(0, gmax));
      end
      send_frame(1'b1, cmd, 1'b1);
   endtask

   // CRC as remainder of (message * x^4) divided by x^4+x+1
   function automatic logic [3:0] crc_ref(input logic [7:0] d[$], input logic [2:0] o);
      bit       msg[$];
      logic [4:0] r;
      foreach (d[i]) for (int b = 7; b >= 0; b--) msg.push_back(d[i][b]);
      msg.push_back(1'b1);
      for (int b = 2; b >= 0; b--) msg.push_back(o[b]);
      repeat (4) msg.push_back(1'b0);
      r = '0;
      foreach (msg[i]) begin
         r = {r[3:0], msg[i]};
         if (r[4]) r = r ^ 5'b10011;
      end
      return r[3:0];
   endfunction

   task automatic model(input logic [7:0] d[$], input logic [7:0] cmd,
                        output logic [W-1:0] ea, output logic [W-1:0] eb,
                        output logic [2:0] eop, output logic [3:0] eerr);
      eop = cmd[6:4];
      ea = '0; eb = '0;
      if (d.size() != 2*OB)                        eerr = 4'b0100;
      else if (cmd[3:0] != crc_ref(d, cmd[6:4]))   eerr = 4'b0010;
      else if (eop inside {3'b000, 3'b001, 3'b100, 3'b101}) eerr = 4'b0000;
      else                                         eerr = 4'b0001;
      if (eerr == 4'b0100) eop = 3'b000;
      else for (int i = 0; i < 2*OB; i++) begin
         if (i < OB) eb = (eb << 8) | W'(d[i]);
         else        ea = (ea << 8) | W'(d[i]);
      end
   endtask

   task automatic check_res(input string tag, input logic [7:0] d[$], input logic [7:0] cmd);
      logic [W-1:0] ea, eb;
      logic [2:0]   eop;
      logic [3:0]   eerr;
      model(d, cmd, ea, eb, eop, eerr);
      chk({tag, ".vld"}, out_valid, 1'b1);
      chk({tag, ".A"}, A, ea);
      chk({tag, ".B"}, B, eb);
      chk({tag, ".op"}, op, eop);
      chk({tag, ".err"}, err, eerr);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".vld"}, out_valid, 1'b0);
      chk({tag, ".drop"}, drop, 1'b0);
      chk({tag, ".A"}, A, '0);
      chk({tag, ".B"}, B, '0);
      chk({tag, ".op"}, op, '0);
      chk({tag, ".err"}, err, '0);
   endtask

   function automatic logic [7:0] good_cmd(input logic [7:0] d[$], input logic [2:0] o);
      return {1'b0, o, crc_ref(d, o)};
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] z[$], d[$], d2[$];
      logic [W-1:0] ha, hb;
      int dc, hc, n;
      rst_n = 1'b0; sin = 1'b1; out_ready = 1'b1;
      tick(3);
      check_zero("reset");
      @(negedge clk) rst_n = 1'b1;
      tick(2);

      z = {};
      repeat (8) z.push_back(8'h00);
      send_pkt(z, 8'h0B, 2);  check_res("zero_ok", z, 8'h0B);
      chk("zero_ok.err_lit", err, 4'b0000);
      idle(3);
      send_pkt(z, 8'h0A, 2);  check_res("zero_crc", z, 8'h0A);
      chk("zero_crc.err_lit", err, 4'b0010);
      idle(3);
      send_pkt(z, 8'h2D, 2);  check_res("zero_op", z, 8'h2D);
      chk("zero_op.err_lit", err, 4'b0001);
      idle(3);
      d = z[0:6];
      send_pkt(d, 8'h0B, 2);  check_res("cnt7", d, 8'h0B);
      chk("cnt7.err_lit", err, 4'b0100);
      idle(3);
      d = z; d.push_back(8'h00);
      send_pkt(d, 8'h0B, 2);  check_res("cnt9", d, 8'h0B);
      idle(3);

      // bad stop bit on byte 3, line held low
      hc = hs_cnt;
      send_frame(1'b0, 8'h12, 1'b1);
      send_frame(1'b0, 8'h34, 1'b1);
      send_frame(1'b0, 8'h56, 1'b0);
      chk("frm.vld", out_valid, 1'b1);
      chk("frm.err", err, 4'b1000);
      chk("frm.A", A, '0);
      chk("frm.op", op, '0);
      sin = 1'b0; tick(20);
      chk("frm.resync_hs", hs_cnt - hc, 1);
      idle(2);
      d = {};
      repeat (8) d.push_back(8'($urandom));
      send_pkt(d, good_cmd(d, 3'b100), 2); check_res("after_frm", d, good_cmd(d, 3'b100));
      idle(3);

      // reset in the middle of a packet
      dc = drop_cnt;
      for (int i = 0; i < 3; i++) send_frame(1'b0, 8'hA5, 1'b1);
      rst_n = 1'b0; #1;
      check_zero("midrst");
      tick(3);
      @(negedge clk) rst_n = 1'b1;
      tick(1);
      chk("midrst.nodrop", drop_cnt - dc, 0);
      d = {};
      repeat (8) d.push_back(8'($urandom));
      send_pkt(d, good_cmd(d, 3'b001), 2); check_res("after_rst", d, good_cmd(d, 3'b001));
      idle(3);

      // back-pressure: first result held, second dropped
      out_ready = 1'b0;
      dc = drop_cnt;
      d = {}; d2 = {};
      repeat (8) begin d.push_back(8'($urandom)); d2.push_back(8'($urandom)); end
      send_pkt(d, good_cmd(d, 3'b101), 2); check_res("hold1", d, good_cmd(d, 3'b101));
      ha = A; hb = B;
      idle(4);
      send_pkt(d2, good_cmd(d2, 3'b000), 2);
      check_res("hold2", d, good_cmd(d, 3'b101));
      tick(1);
      chk("hold.drop", drop_cnt - dc, 1);
      chk("hold.A_stable", A, ha);
      chk("hold.B_stable", B, hb);
      out_ready = 1'b1;
      tick(1);
      chk("hold.release", out_valid, 1'b0);
      idle(3);

      // inter-frame timeout
      dc = drop_cnt; hc = hs_cnt;
      for (int i = 0; i < 3; i++) send_frame(1'b0, 8'h3C, 1'b1);
      idle(TMO + 5);
      chk("tmo.drop", drop_cnt - dc, 1);
      chk("tmo.novld", hs_cnt - hc, 0);
      d = {};
      repeat (8) d.push_back(8'($urandom));
      send_pkt(d, good_cmd(d, 3'b000), TMO - 2); check_res("after_tmo", d, good_cmd(d, 3'b000));
      idle(3);

      // random packets
      for (int k = 0; k < 40; k++) begin
         logic [7:0] cmd;
         d = {};
         n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : 8;
         repeat (n) d.push_back(8'($urandom));
         cmd = ($urandom_range(0, 3) != 0) ? good_cmd(d, 3'($urandom)) : 8'($urandom);
         send_pkt(d, cmd, 3);
         check_res($sformatf("rnd%0d", k), d, cmd);
         idle($urandom_range(1, 4));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule
